// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: supported opcode/funct encodings
// and the issue controller state type.
package alu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  function automatic logic instr_is_legal(input logic [5:0] opcode,
                                          input logic [5:0] funct);
    logic legal;
    legal = 1'b0;
    if (opcode == OP_RTYPE) begin
      legal = (funct == FN_ADD) || (funct == FN_SUB);
    end else if ((opcode == OP_ADDI) || (opcode == OP_ANDI)) begin
      legal = 1'b1;
    end
    return legal;
  endfunction

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational MIPS instruction decode into ALU operand fields plus a
// legality flag for the small supported subset.
module alu_instr_decode
  import alu_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [31:0]      instr,
  output logic [REG_W-1:0] a,
  output logic [REG_W-1:0] b,
  output logic [5:0]       func,
  output logic [5:0]       opcode,
  output logic             legal
);

  // Immediate bits above the 5-bit operand slice are not forwarded to the ALU.
  logic unused_imm_bits;
  assign unused_imm_bits = ^instr[15:6];

  always_comb begin
    opcode = instr[31:26];
    a      = REG_W'(instr[25:21]);
    legal  = instr_is_legal(instr[31:26], instr[5:0]);
    if (instr[31:26] == OP_RTYPE) begin
      b    = REG_W'(instr[20:16]);
      func = instr[5:0];
    end else begin
      b    = REG_W'(instr[4:0]);
      func = '0;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational ALU: accepts an instruction, holds the
// decoded operands for ALU_LAT cycles, captures the result and hands it back.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [REG_W-1:0]  alu_a,
  output logic [REG_W-1:0]  alu_b,
  output logic [5:0]        alu_func,
  output logic [5:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(ALU_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [REG_W-1:0] dec_a;
  logic [REG_W-1:0] dec_b;
  logic [5:0]       dec_func;
  logic [5:0]       dec_opcode;
  logic             dec_legal;

  alu_instr_decode #(
    .REG_W (REG_W)
  ) u_decode (
    .instr  (instr),
    .a      (dec_a),
    .b      (dec_b),
    .func   (dec_func),
    .opcode (dec_opcode),
    .legal  (dec_legal)
  );

  assign instr_ready = (state == IDLE);
  assign res_valid   = (state == RESP);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_func   <= '0;
      alu_opcode <= '0;
      res_data   <= '0;
      res_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            if (dec_legal) begin
              alu_a      <= dec_a;
              alu_b      <= dec_b;
              alu_func   <= dec_func;
              alu_opcode <= dec_opcode;
              cnt        <= '0;
              state      <= ISSUE;
            end else begin
              // Unsupported words skip the ALU entirely; its ports stay at 0.
              res_data <= '0;
              res_err  <= 1'b1;
              state    <= RESP;
            end
          end
        end
        ISSUE: begin
          if (cnt == CNT_LAST) begin
            res_data <= alu_result;
            res_err  <= 1'b0;
            state    <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (res_ready) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_func   <= '0;
            alu_opcode <= '0;
            res_data   <= '0;
            res_err    <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with ALU_LAT=4 and a behavioural ALU that
// only returns a real result once its operands have been held long enough.
module tb_alu_issue_ctrl;

  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  alu_a;
  logic [4:0]  alu_b;
  logic [5:0]  alu_func;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_result;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .ALU_LAT (LAT),
    .DATA_W  (32),
    .REG_W   (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_func    (alu_func),
    .alu_opcode  (alu_opcode),
    .alu_result  (alu_result),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_err     (res_err),
    .busy        (busy)
  );

  // ALU model: garbage until the operands have been stable for LAT cycles,
  // so an early capture by the controller shows up as a wrong res_data.
  logic [21:0] cur_ports;
  logic [21:0] last_ports = '0;
  int unsigned age = 0;
  assign cur_ports = {alu_a, alu_b, alu_func, alu_opcode};

  always @(posedge clk) begin
    age        <= (cur_ports == last_ports) ? age + 1 : 0;
    last_ports <= cur_ports;
  end

  function automatic logic [31:0] alu_f(input logic [4:0] a, input logic [4:0] b,
                                        input logic [5:0] fn, input logic [5:0] op);
    logic [31:0] r;
    r = 32'd0;
    if (op == 6'b000000 && fn == 6'b100000) r = 32'(a) + 32'(b);
    else if (op == 6'b000000 && fn == 6'b100010) r = 32'(a) - 32'(b);
    else if (op == 6'b001000) r = 32'(a) + 32'(b);
    else if (op == 6'b001100) r = 32'(a & b);
    return r;
  endfunction

  always_comb begin
    alu_result = 32'hBAD0_0BAD;
    if (cur_ports == last_ports && age >= LAT - 2)
      alu_result = alu_f(alu_a, alu_b, alu_func, alu_opcode);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; instr_valid = 1'b0; res_ready = 1'b0; instr = '0;
    tick; tick;
    n_cmp++;
    if ({instr_ready, busy, res_valid} !== 3'b100) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 100", {instr_ready, busy, res_valid});
    end
    n_cmp++;
    if (cur_ports !== 22'd0) begin
      n_bad++; $display("FAIL reset_ports: got %h want 0", cur_ports);
    end
    n_cmp++;
    if ({res_data, res_err} !== 33'd0) begin
      n_bad++; $display("FAIL reset_res: got %h/%b want 0/0", res_data, res_err);
    end
    rst = 1'b0;
    tick;
    n_cmp++;
    if ({instr_ready, busy, res_valid} !== 3'b100) begin
      n_bad++; $display("FAIL post_reset_idle: got %b want 100", {instr_ready, busy, res_valid});
    end
  endtask

  // Accept one instruction, check the ISSUE window, the result, then consume it.
  task automatic run_instr(input string name, input logic [31:0] w,
                           input logic [21:0] exp_ports, input logic [31:0] exp_data,
                           input logic exp_err);
    instr = w; instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0; instr = '0;
    n_cmp++;
    if ({busy, instr_ready} !== 2'b10) begin
      n_bad++; $display("FAIL %s_accept: busy/ready got %b want 10", name, {busy, instr_ready});
    end
    if (!exp_err) begin
      for (int unsigned j = 0; j < LAT; j++) begin
        n_cmp++;
        if ({res_valid, cur_ports} !== {1'b0, exp_ports}) begin
          n_bad++; $display("FAIL %s_issue%0d: valid/ports got %b/%h want 0/%h",
                            name, j, res_valid, cur_ports, exp_ports);
        end
        tick;
      end
    end
    n_cmp++;
    if ({res_valid, res_data, res_err} !== {1'b1, exp_data, exp_err}) begin
      n_bad++; $display("FAIL %s_result: valid/data/err got %b/%h/%b want 1/%h/%b",
                        name, res_valid, res_data, res_err, exp_data, exp_err);
    end
    if (exp_err) begin
      n_cmp++;
      if (cur_ports !== 22'd0) begin
        n_bad++; $display("FAIL %s_ports_untouched: got %h want 0", name, cur_ports);
      end
    end
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    n_cmp++;
    if ({res_valid, instr_ready, busy, cur_ports} !== {3'b010, 22'd0}) begin
      n_bad++; $display("FAIL %s_done: valid/ready/busy/ports got %b/%b/%b/%h want 0/1/0/0",
                        name, res_valid, instr_ready, busy, cur_ports);
    end
  endtask

  task automatic test_add;
    run_instr("add", 32'h00C3_0020, {5'd6, 5'd3, 6'b100000, 6'b000000}, 32'd9, 1'b0);
  endtask

  task automatic test_itype;
    run_instr("addi", 32'h2140_0005, {5'd10, 5'd5, 6'd0, 6'b001000}, 32'd15, 1'b0);
    run_instr("andi", 32'h3180_0004, {5'd12, 5'd4, 6'd0, 6'b001100}, 32'd4, 1'b0);
  endtask

  task automatic test_unsupported;
    run_instr("lw", 32'h8C00_0000, 22'd0, 32'd0, 1'b1);
    run_instr("rtype_and", 32'h00C3_0024, 22'd0, 32'd0, 1'b1);
  endtask

  task automatic test_stall;
    instr = 32'h0124_0022; instr_valid = 1'b1;
    tick;
    instr = 32'h00C3_0020;
    for (int unsigned j = 0; j < LAT; j++) tick;
    for (int unsigned j = 0; j < 5; j++) begin
      n_cmp++;
      if ({res_valid, instr_ready, res_data, res_err} !== {2'b10, 32'd5, 1'b0}) begin
        n_bad++; $display("FAIL stall%0d: valid/ready/data/err got %b/%b/%h/%b want 1/0/5/0",
                          j, res_valid, instr_ready, res_data, res_err);
      end
      tick;
    end
    instr_valid = 1'b0;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    n_cmp++;
    if ({res_valid, instr_ready, busy} !== 3'b010) begin
      n_bad++; $display("FAIL stall_release: valid/ready/busy got %b want 010",
                        {res_valid, instr_ready, busy});
    end
  endtask

  task automatic test_reset_abort;
    instr = 32'h00C3_0020; instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_cmp++;
    if ({instr_ready, busy, res_valid, cur_ports} !== {3'b100, 22'd0}) begin
      n_bad++; $display("FAIL abort_state: ready/busy/valid/ports got %b/%b/%b/%h want 1/0/0/0",
                        instr_ready, busy, res_valid, cur_ports);
    end
    for (int unsigned j = 0; j < LAT + 2; j++) begin
      tick;
      n_cmp++;
      if ({res_valid, busy} !== 2'b00) begin
        n_bad++; $display("FAIL abort_quiet%0d: valid/busy got %b want 00", j, {res_valid, busy});
      end
    end
    run_instr("add_after_abort", 32'h00C3_0020, {5'd6, 5'd3, 6'b100000, 6'b000000}, 32'd9, 1'b0);
  endtask

  task automatic test_back_to_back;
    int acc[$];
    instr = 32'h00C3_0020; instr_valid = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 40 && acc.size() < 3; i++) begin
      if (instr_ready) acc.push_back(i);
      if (res_valid) begin
        n_cmp++;
        if ({res_data, res_err} !== {32'd9, 1'b0}) begin
          n_bad++; $display("FAIL b2b_result: data/err got %h/%b want 9/0", res_data, res_err);
        end
      end
      tick;
    end
    instr_valid = 1'b0;
    n_cmp++;
    if (acc.size() != 3) begin
      n_bad++; $display("FAIL b2b_accepts: got %0d accepts want 3", acc.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (acc[k+1] - acc[k] != int'(LAT + 2)) begin
          n_bad++; $display("FAIL b2b_spacing%0d: got %0d want %0d", k, acc[k+1] - acc[k], LAT + 2);
        end
      end
    end
    for (int i = 0; i < 20 && busy; i++) tick;
    res_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL b2b_drain: busy got %b want 0", busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_add;
    test_itype;
    test_unsupported;
    test_stall;
    test_reset_abort;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
